// File: rtl/picomips_io_sequencer.sv
// Operator I/O sequencer for the picoMIPS affine datapath: debounces the Go switch,
// captures two operands, launches one computation and shows both results on the LEDs.
module picomips_io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CALC_TIMEOUT    = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Go,
    input  logic [7:0] Sw_data,
    input  logic       calc_done,
    input  logic [7:0] x2_in,
    input  logic [7:0] y2_in,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic       calc_start,
    output logic [7:0] LED,
    output logic [3:0] state_o,
    output logic       error
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] TO_LIMIT = 8'(CALC_TIMEOUT);

    typedef enum logic [3:0] {
        WAIT_X_HI = 4'd0,
        WAIT_X_LO = 4'd1,
        WAIT_Y_HI = 4'd2,
        WAIT_Y_LO = 4'd3,
        CALC      = 4'd4,
        SHOW_X2   = 4'd5,
        SHOW_Y2   = 4'd6
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       go_meta;
    logic       go_sync;
    logic       go_db;
    logic       go_db_q;
    logic [7:0] db_count;
    logic [7:0] db_count_inc;
    logic       go_rise;
    logic       go_fall;

    logic [7:0] calc_count;
    logic [7:0] calc_count_inc;
    logic [7:0] x2_lat;
    logic [7:0] y2_lat;

    logic       capture_x;
    logic       capture_y;
    logic       accept_result;
    logic       timeout;
    logic       show_y;

    assign db_count_inc   = (db_count == 8'hFF) ? 8'hFF : db_count + 8'd1;
    assign calc_count_inc = (calc_count == 8'hFF) ? 8'hFF : calc_count + 8'd1;
    assign go_rise        = go_db & ~go_db_q;
    assign go_fall        = ~go_db & go_db_q;

    // Two-flop synchroniser, then go_db only flips after a full run of disagreeing samples
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            go_meta  <= 1'b0;
            go_sync  <= 1'b0;
            go_db    <= 1'b0;
            go_db_q  <= 1'b0;
            db_count <= 8'd0;
        end else begin
            go_meta <= Go;
            go_sync <= go_meta;
            go_db_q <= go_db;
            if (go_sync == go_db) begin
                db_count <= 8'd0;
            end else if (db_count_inc >= DB_LIMIT) begin
                go_db    <= go_sync;
                db_count <= 8'd0;
            end else begin
                db_count <= db_count_inc;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= WAIT_X_HI;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        capture_x     = 1'b0;
        capture_y     = 1'b0;
        accept_result = 1'b0;
        timeout       = 1'b0;
        show_y        = 1'b0;
        case (state)
            WAIT_X_HI: if (go_rise) begin
                next_state = WAIT_X_LO;
                capture_x  = 1'b1;
            end
            WAIT_X_LO: if (go_fall) next_state = WAIT_Y_HI;
            WAIT_Y_HI: if (go_rise) begin
                next_state = WAIT_Y_LO;
                capture_y  = 1'b1;
            end
            WAIT_Y_LO: if (go_fall) next_state = CALC;
            // A done arriving on the terminal-count cycle still wins over the timeout
            CALC: begin
                if (calc_done) begin
                    next_state    = SHOW_X2;
                    accept_result = 1'b1;
                end else if (calc_count_inc >= TO_LIMIT) begin
                    next_state = WAIT_X_HI;
                    timeout    = 1'b1;
                end
            end
            SHOW_X2: if (go_rise) begin
                next_state = SHOW_Y2;
                show_y     = 1'b1;
            end
            SHOW_Y2: if (go_fall) next_state = WAIT_X_HI;
            default: next_state = WAIT_X_HI;
        endcase
    end

    // calc_count is zero on the first CALC cycle, which is exactly when calc_start fires
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            calc_count <= 8'd0;
        end else if (state != CALC) begin
            calc_count <= 8'd0;
        end else begin
            calc_count <= calc_count_inc;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            x_data <= 8'd0;
            y_data <= 8'd0;
            x2_lat <= 8'd0;
            y2_lat <= 8'd0;
            LED    <= 8'd0;
            error  <= 1'b0;
        end else begin
            if (capture_x) x_data <= Sw_data;
            if (capture_y) y_data <= Sw_data;
            if (accept_result) begin
                x2_lat <= x2_in;
                y2_lat <= y2_in;
                LED    <= x2_in;
                error  <= 1'b0;
            end
            if (timeout) begin
                LED   <= 8'hFF;
                error <= 1'b1;
            end
            if (show_y) LED <= y2_lat;
        end
    end

    assign calc_start = (state == CALC) && (calc_count == 8'd0);
    assign state_o    = state;

endmodule

// File: doc/picomips_io_sequencer.md
PICOMIPS_IO_SEQUENCER -- requirements
Module: picomips_io_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronised Go samples required to accept a Go level change; legal range 1..255.
REQ-002 Parameter CALC_TIMEOUT, default 64: maximum cycles allowed from calc_start to calc_done before error; legal range 1..255.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Go  input  1  raw handshake switch (SW8 equivalent); asynchronous to Clock.
REQ-006 Sw_data  input  8  operand switches (SW[7:0] equivalent), sampled only on capture.
REQ-007 calc_done  input  1  single-cycle pulse from datapath when x2/y2 are valid.
REQ-008 x2_in, y2_in  input  8 each  signed results from datapath.
REQ-009 x_data, y_data  output  8 each  captured operands, held until next capture.
REQ-010 calc_start  output  1  single-cycle pulse requesting one affine computation.
REQ-011 LED  output  8  display value.
REQ-012 state_o  output  4  current state encoding (debug).
REQ-013 error  output  1  sticky calc-timeout flag.

Function
REQ-014 Go SHALL pass through a 2-flop synchroniser, then a debounce counter; go_db SHALL change only after DEBOUNCE_CYCLES consecutive synchronised samples differ from go_db; any matching sample clears the counter.
REQ-015 States SHALL be: WAIT_X_HI, WAIT_X_LO, WAIT_Y_HI, WAIT_Y_LO, CALC, SHOW_X2, SHOW_Y2 (encodings 0..6 on state_o).
REQ-016 WAIT_X_HI -> WAIT_X_LO on go_db rising; x_data <= Sw_data in the same cycle as the transition.
REQ-017 WAIT_X_LO -> WAIT_Y_HI on go_db falling.
REQ-018 WAIT_Y_HI -> WAIT_Y_LO on go_db rising; y_data <= Sw_data in the same cycle.
REQ-019 WAIT_Y_LO -> CALC on go_db falling; calc_start SHALL be asserted for exactly the first cycle in CALC.
REQ-020 CALC -> SHOW_X2 on calc_done; x2_in and y2_in SHALL be latched internally on that cycle.
REQ-021 CALC SHALL count cycles from calc_start; if count reaches CALC_TIMEOUT without calc_done, error SHALL set, LED SHALL show 8'hFF, FSM -> WAIT_X_HI.
REQ-022 calc_done outside CALC SHALL be ignored.
REQ-023 SHOW_X2: LED = latched x2; -> SHOW_Y2 on go_db rising.
REQ-024 SHOW_Y2: LED = latched y2; -> WAIT_X_HI on go_db falling; LED keeps y2 until next SHOW_X2 or timeout.
REQ-025 In all states other than SHOW_X2/SHOW_Y2/timeout, LED SHALL hold its last value.
REQ-026 calc_done coincident with timeout terminal count SHALL be treated as success (no error).
REQ-027 error SHALL clear only on Reset or on the next successful calc_done.
REQ-028 Go glitches shorter than DEBOUNCE_CYCLES SHALL cause no state change and no capture.
REQ-029 Debounce and timeout counters SHALL saturate, never wrap.

Reset
REQ-030 Reset assertion SHALL immediately force state WAIT_X_HI, x_data, y_data, LED, latched results = 0, calc_start = 0, error = 0, counters = 0, synchroniser and go_db = 0.
REQ-031 Reset mid-CALC SHALL abort; a calc_done arriving after release SHALL be ignored.
REQ-032 After Reset release, a Go held high from before reset SHALL be seen as a rising edge once debounced.

Verification
REQ-033 Full flow: Sw_data=10,Go up/down; Sw_data=20,Go up/down; calc_done after 5 cycles with x2=37,y2=-15 -> x_data=10,y_data=20, one calc_start pulse, LED=37, Go up -> LED=-15 (8'hF1), Go down -> WAIT_X_HI.
REQ-034 Bounce: Go high 3 cycles then low, DEBOUNCE_CYCLES=4 -> no capture, state stays WAIT_X_HI.
REQ-035 Timeout: no calc_done for 64 cycles -> error=1, LED=8'hFF, state WAIT_X_HI; next successful run clears error.
REQ-036 Coincidence: calc_done on cycle 64 -> error stays 0, LED=x2.
REQ-037 Reset asserted in CALC, calc_done pulsed after release -> all outputs 0, state WAIT_X_HI, no LED change.
REQ-038 Stray calc_done in WAIT_Y_HI -> no state or LED change.
